dragon_move_ctrl: RTL and testbench

//  Sequencer for the dragon body shift register (8 x 12-bit segments + tail pointer).

---
 rtl/dragon_pkg.sv | 52 +++++
 rtl/dragon_next_pos.sv | 38 +++
 rtl/dragon_move_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dragon_move_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragon_pkg.sv
// ============================================================================
// Module  : dragon_pkg
// Brief   : Shared codes and helpers for the dragon sequencer and body store.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dragon_pkg;

    localparam int GRID_BITS = 4;
    localparam int SEG_W     = 12;

    typedef enum logic [1:0] {
        ST_MOVE = 2'b00,
        ST_HEAL = 2'b01,
        ST_HIT  = 2'b10,
        ST_IDLE = 2'b11
    } upd_state_e;

    // Orientation one-hots, bit order {W,S,E,N}
    localparam logic [3:0] OR_N = 4'b0001;
    localparam logic [3:0] OR_E = 4'b0010;
    localparam logic [3:0] OR_S = 4'b0100;
    localparam logic [3:0] OR_W = 4'b1000;

    typedef enum logic [1:0] {
        FSM_WAIT  = 2'd0,
        FSM_CALC  = 2'd1,
        FSM_ISSUE = 2'd2,
        FSM_DEAD  = 2'd3
    } fsm_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] reverse_dir(input logic [3:0] o);
        logic [3:0] r;
        r = 4'd0;
        case (o)
            OR_N:    r = OR_S;
            OR_E:    r = OR_W;
            OR_S:    r = OR_N;
            OR_W:    r = OR_E;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dragon_next_pos.sv
// ============================================================================
// Module  : dragon_next_pos
// Brief   : Combinational one-cell step of a head position on the wrapping grid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dragon_next_pos
    import dragon_pkg::*;
(
    input  logic [3:0]           orient_i,
    input  logic [GRID_BITS-1:0] y_i,
    input  logic [GRID_BITS-1:0] x_i,
    output logic [GRID_BITS-1:0] y_o,
    output logic [GRID_BITS-1:0] x_o
);

    localparam logic [GRID_BITS-1:0] ONE = GRID_BITS'(1);

    // Wrap-around falls out of the natural GRID_BITS-wide overflow
    always_comb begin
        y_o = y_i;
        x_o = x_i;
        case (orient_i)
            OR_E:    x_o = x_i + ONE;
            OR_W:    x_o = x_i - ONE;
            OR_N:    y_o = y_i - ONE;
            OR_S:    y_o = y_i + ONE;
            default: begin
                y_o = y_i;
                x_o = x_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dragon_move_ctrl.sv
// ============================================================================
// Module  : dragon_move_ctrl
// Brief   : Per-period head stepper, event arbiter and length/death tracker
//           feeding the dragon body store over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dragon_move_ctrl
    import dragon_pkg::*;
#(
    parameter int         MOVE_DIV = 4,
    parameter int         MAX_LEN  = 8,
    parameter logic [3:0] START_X  = 4'd8,
    parameter logic [3:0] START_Y  = 4'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick_i,
    input  logic             run_i,
    input  logic [3:0]       dir_req_i,
    input  logic             heal_req_i,
    input  logic             hit_req_i,
    input  logic             upd_ready_i,
    output logic             upd_valid_o,
    output logic [1:0]       upd_state_o,
    output logic [SEG_W-1:0] upd_data_o,
    output logic [3:0]       length_o,
    output logic             dead_o
);

    localparam logic [3:0] PRESC_LAST = 4'(MOVE_DIV - 1);
    localparam logic [3:0] MAX_LEN_C  = 4'(MAX_LEN);

    fsm_e                 state_q, state_d;
    logic [3:0]           presc_q, presc_d;
    logic [3:0]           next_dir_q, next_dir_d;
    logic [3:0]           orient_q, orient_d;
    logic [GRID_BITS-1:0] y_q, y_d;
    logic [GRID_BITS-1:0] x_q, x_d;
    upd_state_e           upd_state_q, upd_state_d;
    logic [3:0]           length_q, length_d;
    logic                 dead_q, dead_d;
    logic                 pend_heal_q, pend_heal_d;
    logic                 pend_hit_q, pend_hit_d;

    logic                 handshake;
    logic [GRID_BITS-1:0] step_y;
    logic [GRID_BITS-1:0] step_x;

    dragon_next_pos u_next_pos (
        .orient_i (next_dir_q),
        .y_i      (y_q),
        .x_i      (x_q),
        .y_o      (step_y),
        .x_o      (step_x)
    );

    assign handshake   = (state_q == FSM_ISSUE) && upd_ready_i;
    assign upd_valid_o = (state_q == FSM_ISSUE);
    assign upd_state_o = upd_state_q;
    assign upd_data_o  = {orient_q, y_q, x_q};
    assign length_o    = length_q;
    assign dead_o      = dead_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FSM_WAIT;
            presc_q     <= 4'd0;
            next_dir_q  <= OR_E;
            orient_q    <= OR_E;
            y_q         <= START_Y;
            x_q         <= START_X;
            upd_state_q <= ST_IDLE;
            length_q    <= 4'd1;
            dead_q      <= 1'b0;
            pend_heal_q <= 1'b0;
            pend_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            next_dir_q  <= next_dir_d;
            orient_q    <= orient_d;
            y_q         <= y_d;
            x_q         <= x_d;
            upd_state_q <= upd_state_d;
            length_q    <= length_d;
            dead_q      <= dead_d;
            pend_heal_q <= pend_heal_d;
            pend_hit_q  <= pend_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        next_dir_d  = next_dir_q;
        orient_d    = orient_q;
        y_d         = y_q;
        x_d         = x_q;
        upd_state_d = upd_state_q;
        length_d    = length_q;
        dead_d      = dead_q;
        pend_heal_d = pend_heal_q;
        pend_hit_d  = pend_hit_q;

        // Reversal is judged against the committed heading, not the pending one
        if (is_onehot4(dir_req_i) && (dir_req_i != reverse_dir(orient_q))) begin
            next_dir_d = dir_req_i;
        end

        // Clear-then-set so a pulse in the handshake cycle survives
        if (state_q != FSM_DEAD) begin
            if (handshake) begin
                pend_heal_d = 1'b0;
                pend_hit_d  = 1'b0;
            end
            if (heal_req_i) pend_heal_d = 1'b1;
            if (hit_req_i)  pend_hit_d  = 1'b1;
        end

        case (state_q)
            FSM_WAIT: begin
                if (run_i && !dead_q && frame_tick_i) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = 4'd0;
                        state_d = FSM_CALC;
                    end else begin
                        presc_d = presc_q + 4'd1;
                    end
                end
            end
            FSM_CALC: begin
                state_d     = FSM_ISSUE;
                orient_d    = next_dir_q;
                y_d         = step_y;
                x_d         = step_x;
                upd_state_d = ST_MOVE;
                if (pend_heal_q && !pend_hit_q && (length_q < MAX_LEN_C)) begin
                    upd_state_d = ST_HEAL;
                end else if (pend_hit_q && !pend_heal_q) begin
                    if (length_q > 4'd1) begin
                        upd_state_d = ST_HIT;
                    end else begin
                        // Fatal hit: head is not advanced, so upd_data keeps the last issued head
                        upd_state_d = ST_IDLE;
                        dead_d      = 1'b1;
                        state_d     = FSM_DEAD;
                        orient_d    = orient_q;
                        y_d         = y_q;
                        x_d         = x_q;
                    end
                end
            end
            FSM_ISSUE: begin
                if (handshake) begin
                    state_d = FSM_WAIT;
                    if (upd_state_q == ST_HEAL) length_d = length_q + 4'd1;
                    if (upd_state_q == ST_HIT)  length_d = length_q - 4'd1;
                end
            end
            FSM_DEAD: begin
                state_d = FSM_DEAD;
            end
            default: state_d = FSM_WAIT;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dragon_move_ctrl.sv
// ============================================================================
// Module  : tb_dragon_move_ctrl
// Brief   : Scoreboard bench for dragon_move_ctrl with directed movement vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dragon_move_ctrl;

    typedef struct packed {
        logic [1:0]  st;
        logic [11:0] data;
        logic [3:0]  len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        run;
    logic [3:0]  dir_req;
    logic        heal_req;
    logic        hit_req;
    logic        upd_ready;
    logic        upd_valid;
    logic [1:0]  upd_state;
    logic [11:0] upd_data;
    logic [3:0]  seg_len;
    logic        dead;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   hs_cnt      = 0;

    dragon_move_ctrl #(
        .MOVE_DIV (4),
        .MAX_LEN  (8),
        .START_X  (4'd8),
        .START_Y  (4'd8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .run_i        (run),
        .dir_req_i    (dir_req),
        .heal_req_i   (heal_req),
        .hit_req_i    (hit_req),
        .upd_ready_i  (upd_ready),
        .upd_valid_o  (upd_valid),
        .upd_state_o  (upd_state),
        .upd_data_o   (upd_data),
        .length_o     (seg_len),
        .dead_o       (dead)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang required finish");
        $fatal(1);
    end

    // Monitor: every accepted update is popped from the scoreboard
    always @(negedge clk) begin
        if (reset && upd_valid && upd_ready) begin
            exp_t e;
            hs_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_update: got state=%0d data=%03h len=%0d required no update",
                         upd_state, upd_data, seg_len);
            end else begin
                e = exp_q.pop_front();
                if ({upd_state, upd_data, seg_len} !== {e.st, e.data, e.len}) begin
                    miscompares++;
                    $display("FAIL update: got state=%0d data=%03h len=%0d required state=%0d data=%03h len=%0d",
                             upd_state, upd_data, seg_len, e.st, e.data, e.len);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_dir(input logic [3:0] d);
        dir_req = d;
        cyc(1);
        dir_req = 4'd0;
    endtask

    task automatic pulse_ev(input logic heal, input logic hit);
        heal_req = heal;
        hit_req  = hit;
        cyc(1);
        heal_req = 1'b0;
        hit_req  = 1'b0;
    endtask

    // One movement period with upd_ready=1; returns after the handshake edge
    task automatic do_step(input logic [1:0] st, input logic [11:0] d, input logic [3:0] len);
        int start;
        exp_q.push_back('{st: st, data: d, len: len});
        start = hs_cnt;
        ticks(4);
        for (int i = 0; i < 20 && hs_cnt == start; i++) cyc(1);
        if (hs_cnt == start) begin
            vectors++;
            miscompares++;
            $display("FAIL step_timeout: got no handshake required data=%03h", d);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        run        = 1'b1;
        dir_req    = 4'd0;
        heal_req   = 1'b0;
        hit_req    = 1'b0;
        upd_ready  = 1'b1;
        cyc(2);
        reset = 1'b1;

        check("rst_valid", 16'(upd_valid), 16'd0);
        check("rst_state", 16'(upd_state), 16'd3);
        check("rst_data",  16'(upd_data),  16'h288);
        check("rst_len",   16'(seg_len),   16'd1);
        check("rst_dead",  16'(dead),      16'd0);

        // First step: two-clock latency, single-cycle valid
        exp_q.push_back('{st: 2'b00, data: 12'h289, len: 4'd1});
        ticks(4);
        check("lat_calc", 16'(upd_valid), 16'd0);
        cyc(1);
        check("lat_issue", 16'(upd_valid), 16'd1);
        cyc(1);
        check("valid_drop", 16'(upd_valid), 16'd0);

        // East wrap 15 -> 0
        for (int i = 10; i <= 15; i++) do_step(2'b00, {4'b0010, 4'd8, 4'(i)}, 4'd1);
        do_step(2'b00, {4'b0010, 4'd8, 4'd0}, 4'd1);

        // North wrap 0 -> 15
        pulse_dir(4'b0001);
        for (int y = 7; y >= 0; y--) do_step(2'b00, {4'b0001, 4'(y), 4'd0}, 4'd1);
        do_step(2'b00, {4'b0001, 4'd15, 4'd0}, 4'd1);

        // Turn east, reversal ignored, turn south, non-one-hot ignored
        pulse_dir(4'b0010);
        do_step(2'b00, {4'b0010, 4'd15, 4'd1}, 4'd1);
        pulse_dir(4'b1000);
        do_step(2'b00, {4'b0010, 4'd15, 4'd2}, 4'd1);
        pulse_dir(4'b0100);
        do_step(2'b00, {4'b0100, 4'd0, 4'd2}, 4'd1);
        pulse_dir(4'b0011);
        do_step(2'b00, {4'b0100, 4'd1, 4'd2}, 4'd1);

        // Heal to full length, then saturate, then heal+hit cancel
        for (int k = 0; k < 7; k++) begin
            pulse_ev(1'b1, 1'b0);
            do_step(2'b01, {4'b0100, 4'(2 + k), 4'd2}, 4'(1 + k));
        end
        check("len_full", 16'(seg_len), 16'd8);
        pulse_ev(1'b1, 1'b0);
        do_step(2'b00, {4'b0100, 4'd9, 4'd2}, 4'd8);
        pulse_ev(1'b1, 1'b1);
        do_step(2'b00, {4'b0100, 4'd10, 4'd2}, 4'd8);
        check("len_cancel", 16'(seg_len), 16'd8);

        // Hits shrink back to one segment
        for (int k = 0; k < 7; k++) begin
            pulse_ev(1'b0, 1'b1);
            do_step(2'b10, {4'b0100, 4'(11 + k), 4'd2}, 4'(8 - k));
        end
        check("len_min", 16'(seg_len), 16'd1);

        // Fatal hit at length 1
        pulse_ev(1'b0, 1'b1);
        ticks(4);
        cyc(4);
        check("dead_state", 16'(upd_state), 16'd3);
        check("dead_flag",  16'(dead),      16'd1);
        check("dead_valid", 16'(upd_valid), 16'd0);
        check("dead_data",  16'(upd_data),  16'h412);
        check("dead_len",   16'(seg_len),   16'd1);
        pulse_ev(1'b1, 1'b0);
        ticks(8);
        cyc(4);
        check("dead_frozen", 16'(upd_valid), 16'd0);
        check("dead_sticky", 16'(dead),      16'd1);
        pulse_reset();
        check("rst2_len",  16'(seg_len),  16'd1);
        check("rst2_dead", 16'(dead),     16'd0);
        check("rst2_data", 16'(upd_data), 16'h288);

        // Pause stalls the prescaler
        run = 1'b0;
        ticks(8);
        cyc(3);
        check("pause_valid", 16'(upd_valid), 16'd0);
        run = 1'b1;

        // Back-pressure: offer held stable
        upd_ready = 1'b0;
        exp_q.push_back('{st: 2'b00, data: 12'h289, len: 4'd1});
        ticks(4);
        for (int i = 0; i < 10 && !upd_valid; i++) cyc(1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 16'(upd_valid), 16'd1);
            check("hold_data",  16'(upd_data),  16'h289);
            check("hold_state", 16'(upd_state), 16'd0);
            cyc(1);
        end
        upd_ready = 1'b1;
        cyc(2);
        check("hold_release", 16'(upd_valid), 16'd0);

        // Reset during a stalled offer drops it
        upd_ready = 1'b0;
        ticks(4);
        for (int i = 0; i < 10 && !upd_valid; i++) cyc(1);
        check("offer2_data", 16'(upd_data), 16'h28a);
        pulse_reset();
        check("rst_drop_valid", 16'(upd_valid), 16'd0);
        check("rst_drop_data",  16'(upd_data),  16'h288);
        upd_ready = 1'b1;
        cyc(2);

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
